avalon_slave_uart: RTL
======================

Name: avalon_slave_uart

Overview:
- Avalon-MM slave UART, 8N1. It is the responder-side counterpart to the UART master bridge.
- A Nios/RISC-V master writes bytes into a TX FIFO, and they are serialised on tx.
- Bytes arriving on rx are deframed into a holding register that the master reads.
- Sits on the system interconnect beside the 7-segment display slave; tx/rx are exported as conduits to the RS-232 pins.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate. CLKS_PER_BIT = CLK_FREQ/BAUD (integer division; 434 at defaults).
- TX_DEPTH, 16, TX FIFO depth in bytes. Must be a power of two, 2 or greater.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- avs_address  in  2  word address: 0=DATA, 1=STATUS, 2=CONTROL, 3=reserved.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, registered.
- irq  out  1  level interrupt.
- rx  in  1  serial input, asynchronous, idle high.
- tx  out  1  serial output, idle high.

Behaviour:
- Reset (synchronous, active-high; takes effect on the clk edge):
  - tx=1, avs_readdata=0, irq=0.
  - TX FIFO empty; RX FSM and TX FSM return to IDLE.
  - rx_valid, overrun and frame_err cleared; CONTROL=0.
  - A reset mid-frame aborts the frame immediately and tx returns high on the next cycle.
- Avalon interface:
  - No waitrequest. Fixed read latency 1: avs_readdata is valid the cycle after avs_read.
  - Simultaneous read and write: both are honoured.
- Register map:
  - DATA write: push writedata[7:0] into the TX FIFO. If the FIFO is full, the write is dropped and tx_drop is set.
  - DATA read: returns {24'b0, rx_byte}. If rx_valid=1, it clears rx_valid in the same cycle. A read with rx_valid=0 returns the stale rx_byte.
  - STATUS read, bits:
    - 0 = rx_valid
    - 1 = tx_full
    - 2 = tx_empty
    - 3 = tx_busy (shifter active)
    - 4 = overrun
    - 5 = frame_err
    - 6 = tx_drop
    - others 0.
  - STATUS write: write-1-to-clear on bits 4..6; other bits are ignored.
  - CONTROL (read/write): bit0 = rx_irq_en, bit1 = tx_empty_irq_en.
  - Address 3: reads 0, writes ignored.
- irq: registered. irq = (rx_valid & rx_irq_en) | (tx_empty & ~tx_busy & tx_empty_irq_en).
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE → START when the FIFO is non-empty; the head byte is popped into the shift register on that cycle.
  - Each state holds for CLKS_PER_BIT cycles. START drives 0.
  - DATA sends 8 bits LSB first.
  - STOP drives 1, then returns to IDLE.
  - Back-to-back bytes have no extra idle gap: STOP → START directly if the FIFO is non-empty.
  - Push and pop on the same cycle with the FIFO full: the pop frees a slot, so the push is accepted.
- RX path:
  - rx passes through a 2-FF synchroniser.
  - FSM states IDLE, START, DATA, STOP.
  - Falling edge in IDLE → START. At CLKS_PER_BIT/2 the line is resampled; if high (glitch), go back to IDLE with no flags set.
  - DATA samples 8 bits at mid-bit, spaced CLKS_PER_BIT apart, LSB first.
  - STOP samples mid-bit:
    - If low: set frame_err and discard the byte.
    - If high and rx_valid=0: load rx_byte and set rx_valid.
    - If high and rx_valid=1: set overrun and drop the new byte; the old byte is kept.
  - After STOP the FSM returns to IDLE at the stop-bit mid-point, so it can resynchronise early.
- Precedence: a DATA read that clears rx_valid on the same cycle as a new byte load → the new byte wins. rx_valid stays 1 and no overrun is flagged.
- Counters: baud counter width is clog2(CLKS_PER_BIT); FIFO pointers are clog2(TX_DEPTH)+1 bits, using the wrap bit for full/empty.

Decomposition:
- Package uart_pkg holds:
  - register address constants (ADDR_DATA/STATUS/CONTROL);
  - STATUS bit indices;
  - FSM state enum {IDLE, START, DATA, STOP}, shared by TX and RX.
- One natural sub-module: uart_tx_fifo (sync FIFO, width 8, TX_DEPTH, push/pop/full/empty). The TX and RX FSMs stay in the top level.

Test Plan:
- Reset mid-frame: write 0x55, assert reset at cycle 1000 → tx=1 on the next cycle, STATUS reads 0x04, irq=0.
- TX single byte: write DATA=0xA5 → tx low for 434 cycles, then bits 1,0,1,0,0,1,0,1, then high for 434 cycles. Total 4340 cycles; STATUS[3] is 1 throughout and 0 afterwards.
- TX FIFO full: write 18 bytes back-to-back while idle → 17 accepted (1 in the shifter, 16 in the FIFO), tx_drop=1, STATUS[1]=1. All 17 appear on tx with no inter-frame gap.
- RX byte plus irq: CONTROL=1, drive 0x3C at 115200 baud → rx_valid=1 and irq=1 after the stop mid-point. DATA read returns 0x3C; rx_valid=0 and irq=0 on the next cycle.
- RX overrun and framing error:
  - Receive 0x11 then 0x22 without reading → DATA=0x11, overrun=1.
  - A frame with stop bit 0 → frame_err=1, rx_valid unchanged.
  - Write STATUS=0x70 → bits 4..6 clear.
- RX glitch: rx low for 100 cycles → no byte received and no flags set; the next valid frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the Avalon-MM UART slave: register map, STATUS
// bit positions and the state encoding used by both the TX and RX FSMs.
package uart_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;

    localparam int ST_RX_VALID  = 0;
    localparam int ST_TX_FULL   = 1;
    localparam int ST_TX_EMPTY  = 2;
    localparam int ST_TX_BUSY   = 3;
    localparam int ST_OVERRUN   = 4;
    localparam int ST_FRAME_ERR = 5;
    localparam int ST_TX_DROP   = 6;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous FIFO feeding the UART transmitter. The head entry is
// presented combinationally so the shifter can load it on the pop cycle.
// A push on a full FIFO is accepted when a pop frees a slot that same cycle.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    // Storage array; no reset needed since the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Pointer update; the extra wrap bit separates full from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/avalon_slave_uart.sv
// Avalon-MM slave UART (8N1). Bytes written to DATA are queued in a TX FIFO
// and serialised on tx; frames arriving on rx land in a holding register
// that the master reads back through DATA. Read latency is one cycle.
module avalon_slave_uart
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int TX_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        irq,
    input  logic        rx,
    output logic        tx
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic        data_wr, data_rd, status_wr, ctrl_wr;
    logic [1:0]  ctrl;
    logic        tx_drop;
    logic [31:0] status_word;
    logic        unused_wdata;

    logic        fifo_full, fifo_empty, tx_pop;
    logic [7:0]  fifo_head;

    uart_state_t      tx_state;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_shift;
    logic             tx_busy;

    uart_state_t      rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_meta, rx_sync, rx_d;
    logic [7:0]       rx_byte;
    logic             rx_valid, overrun, frame_err;

    assign data_wr   = avs_write && (avs_address == ADDR_DATA);
    assign data_rd   = avs_read  && (avs_address == ADDR_DATA);
    assign status_wr = avs_write && (avs_address == ADDR_STATUS);
    assign ctrl_wr   = avs_write && (avs_address == ADDR_CONTROL);

    assign unused_wdata = ^avs_writedata[31:8];

    assign tx_busy = (tx_state != IDLE);
    assign tx_pop  = !fifo_empty &&
                     ((tx_state == IDLE) || ((tx_state == STOP) && (tx_cnt == BIT_LAST)));

    uart_tx_fifo #(
        .DEPTH(TX_DEPTH)
    ) u_tx_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (data_wr),
        .push_data(avs_writedata[7:0]),
        .pop      (tx_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Assemble the STATUS word from the live flags.
    always_comb begin
        status_word               = '0;
        status_word[ST_RX_VALID]  = rx_valid;
        status_word[ST_TX_FULL]   = fifo_full;
        status_word[ST_TX_EMPTY]  = fifo_empty;
        status_word[ST_TX_BUSY]   = tx_busy;
        status_word[ST_OVERRUN]   = overrun;
        status_word[ST_FRAME_ERR] = frame_err;
        status_word[ST_TX_DROP]   = tx_drop;
    end

    // Transmit FSM; STOP chains straight into START when more bytes wait.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= IDLE;
            tx       <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            case (tx_state)
                IDLE: begin
                    tx <= 1'b1;
                    if (!fifo_empty) begin
                        tx_state <= START;
                        tx_shift <= fifo_head;
                        tx       <= 1'b0;
                        tx_cnt   <= '0;
                    end
                end
                START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_state <= DATA;
                        tx       <= tx_shift[0];
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_state <= STOP;
                            tx       <= 1'b1;
                        end else begin
                            tx       <= tx_shift[1];
                            tx_shift <= tx_shift >> 1;
                            tx_bit   <= tx_bit + 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (!fifo_empty) begin
                            tx_state <= START;
                            tx_shift <= fifo_head;
                            tx       <= 1'b0;
                        end else begin
                            tx_state <= IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    // Receive path: synchroniser, mid-bit sampling FSM and the RX flags.
    // A byte landing on the same cycle as a DATA read wins over the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_d      <= 1'b1;
            rx_state  <= IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_d    <= rx_sync;
            if (data_rd) begin
                rx_valid <= 1'b0;
            end
            if (status_wr && avs_writedata[ST_OVERRUN]) begin
                overrun <= 1'b0;
            end
            if (status_wr && avs_writedata[ST_FRAME_ERR]) begin
                frame_err <= 1'b0;
            end
            case (rx_state)
                IDLE: begin
                    if (rx_d && !rx_sync) begin
                        rx_state <= START;
                        rx_cnt   <= '0;
                    end
                end
                START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        rx_state <= rx_sync ? IDLE : DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (rx_bit == 3'd7) begin
                            rx_state <= STOP;
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= IDLE;
                        if (!rx_sync) begin
                            frame_err <= 1'b1;
                        end else if (rx_valid && !data_rd) begin
                            overrun <= 1'b1;
                        end else begin
                            rx_byte  <= rx_shift;
                            rx_valid <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

    // Register file: CONTROL, tx_drop, registered read data and irq.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl         <= '0;
            tx_drop      <= 1'b0;
            avs_readdata <= '0;
            irq          <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                ctrl <= avs_writedata[1:0];
            end
            if (status_wr && avs_writedata[ST_TX_DROP]) begin
                tx_drop <= 1'b0;
            end
            if (data_wr && fifo_full && !tx_pop) begin
                tx_drop <= 1'b1;
            end
            if (avs_read) begin
                case (avs_address)
                    ADDR_DATA:    avs_readdata <= {24'b0, rx_byte};
                    ADDR_STATUS:  avs_readdata <= status_word;
                    ADDR_CONTROL: avs_readdata <= {30'b0, ctrl};
                    default:      avs_readdata <= '0;
                endcase
            end
            irq <= (rx_valid & ctrl[0]) | (fifo_empty & ~tx_busy & ctrl[1]);
        end
    end

endmodule
